cmp_nic: RTL and testbench

- Network interface controller at the far end of the processor's NIC access path, sitting between the processor and the ring router's local port.
- Acts as the responder for processor NIC loads and stores. The processor drives a 2-bit register address, enable, write-enable and 64-bit write data. The NIC returns 64-bit read data one cycle later.
- Holds a one-entry input channel buffer (router to processor) and a one-entry output channel buffer (processor to router), each with a full/empty status bit.
- Uses a ready/valid handshake on the router side, gated by the router's polarity.

---
 rtl/cmp_nic_if.sv | 31 +++
 rtl/cmp_nic.sv | 83 ++++++++
 tb/tb_cmp_nic.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cmp_nic_if.sv
// Processor access port and router local port of the NIC, bundled for cmp_nic.
// The slave modport is the NIC side. The master modport is the processor/router environment side.
interface cmp_nic_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
);
    logic [0:ADDR_WIDTH-1] addr;
    logic [0:DATA_WIDTH-1] d_in;
    logic [0:DATA_WIDTH-1] d_out;
    logic                  nicEn;
    logic                  nicWrEn;
    logic                  net_si;
    logic                  net_ri;
    logic [0:DATA_WIDTH-1] net_di;
    logic                  net_so;
    logic                  net_ro;
    logic [0:DATA_WIDTH-1] net_do;
    logic                  net_polarity;

    modport slave (
        input  addr, d_in, nicEn, nicWrEn,
        input  net_si, net_di, net_ro, net_polarity,
        output d_out, net_ri, net_so, net_do
    );

    modport master (
        output addr, d_in, nicEn, nicWrEn,
        output net_si, net_di, net_ro, net_polarity,
        input  d_out, net_ri, net_so, net_do
    );
endinterface

// File: rtl/cmp_nic.sv
// NIC responder with one-entry input (router->cpu) and output (cpu->router) buffers.
// Bit 0 of a packet is its VC bit; the output packet is only offered while the VC bit matches router polarity.
module cmp_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    cmp_nic_if.slave         bus
);
    localparam logic [0:ADDR_WIDTH-1] A_IB  = 2'd0;
    localparam logic [0:ADDR_WIDTH-1] A_IBS = 2'd1;
    localparam logic [0:ADDR_WIDTH-1] A_OB  = 2'd2;
    localparam logic [0:ADDR_WIDTH-1] A_OBS = 2'd3;

    logic [0:DATA_WIDTH-1] ib_q, ib_d;
    logic [0:DATA_WIDTH-1] ob_q, ob_d;
    logic [0:DATA_WIDTH-1] d_out_q, d_out_d;
    logic                  ibs_q, ibs_d;
    logic                  obs_q, obs_d;

    logic accept, xfer, ld, st;

    assign bus.net_ri = ~ibs_q;
    assign bus.net_so = obs_q & (ob_q[0] == bus.net_polarity);
    assign bus.net_do = ob_q;
    assign bus.d_out  = d_out_q;

    assign accept = bus.net_si & ~ibs_q;
    assign xfer   = bus.net_so & bus.net_ro;
    assign ld     = bus.nicEn & ~bus.nicWrEn;
    assign st     = bus.nicEn & bus.nicWrEn;

    always_comb begin
        ib_d    = ib_q;
        ibs_d   = ibs_q;
        ob_d    = ob_q;
        obs_d   = obs_q;
        d_out_d = d_out_q;

        // Accept needs ibs=0 and the addr0 drain needs ibs=1, so they never collide.
        if (accept) begin
            ib_d  = bus.net_di;
            ibs_d = 1'b1;
        end else if (ld && bus.addr == A_IB && ibs_q) begin
            ibs_d = 1'b0;
        end

        // A store into a full buffer is dropped even if that buffer drains this same edge.
        if (st && bus.addr == A_OB && !obs_q) begin
            ob_d  = bus.d_in;
            obs_d = 1'b1;
        end else if (xfer) begin
            obs_d = 1'b0;
        end

        if (ld) begin
            unique case (bus.addr)
                A_IB:    d_out_d = ib_q;
                A_IBS:   d_out_d = {{(DATA_WIDTH-1){1'b0}}, ibs_q};
                A_OB:    d_out_d = ob_q;
                A_OBS:   d_out_d = {{(DATA_WIDTH-1){1'b0}}, obs_q};
                default: d_out_d = d_out_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ib_q    <= '0;
            ob_q    <= '0;
            d_out_q <= '0;
            ibs_q   <= 1'b0;
            obs_q   <= 1'b0;
        end else begin
            ib_q    <= ib_d;
            ob_q    <= ob_d;
            d_out_q <= d_out_d;
            ibs_q   <= ibs_d;
            obs_q   <= obs_d;
        end
    end
endmodule

// File: tb/tb_cmp_nic.sv
// Directed bench for cmp_nic: buffer fill/drain, VC gating, dropped stores, async reset.
module tb_cmp_nic;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    localparam logic [0:63] PKT_A  = 64'hA5A5_0000_0000_0001;
    localparam logic [0:63] ST_V0  = 64'h0123_4567_89AB_CDEF;
    localparam logic [0:63] X1     = 64'h1111_2222_3333_4444;
    localparam logic [0:63] X2     = 64'h2222_3333_4444_5555;
    localparam logic [0:63] X3     = 64'h3333_4444_5555_6666;
    localparam logic [0:63] X4     = 64'h8000_0000_0000_00FF;
    localparam logic [0:63] P1     = 64'hDEAD_BEEF_0000_0001;
    localparam logic [0:63] P2     = 64'hCAFE_0000_0000_0002;
    localparam logic [0:63] P3     = 64'h0F0F_0F0F_0F0F_0F0F;
    localparam logic [0:63] ZERO   = 64'h0;
    localparam logic [0:63] ONE    = 64'h1;

    always #5 clk = ~clk;

    cmp_nic_if nif ();

    cmp_nic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (nif)
    );

    task automatic check(input string tag, input logic [0:63] observed, input logic [0:63] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [0:1] a);
        nif.nicEn = 1'b1; nif.nicWrEn = 1'b0; nif.addr = a;
        tick();
        nif.nicEn = 1'b0;
    endtask

    task automatic store(input logic [0:1] a, input logic [0:63] v);
        nif.nicEn = 1'b1; nif.nicWrEn = 1'b1; nif.addr = a; nif.d_in = v;
        tick();
        nif.nicEn = 1'b0; nif.nicWrEn = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nif.addr = 2'd0; nif.d_in = '0; nif.nicEn = 1'b0; nif.nicWrEn = 1'b0;
        nif.net_si = 1'b0; nif.net_di = '0; nif.net_ro = 1'b0; nif.net_polarity = 1'b0;

        // 1: reset state
        #12;
        check("rst_net_ri", {63'b0, nif.net_ri}, ONE);
        check("rst_net_so", {63'b0, nif.net_so}, ZERO);
        check("rst_d_out", nif.d_out, ZERO);
        @(negedge clk); reset = 1'b1;
        load(2'd1); check("t1_ibs", nif.d_out, ZERO);
        load(2'd3); check("t1_obs", nif.d_out, ZERO);
        check("t1_net_ri", {63'b0, nif.net_ri}, ONE);
        check("t1_net_so", {63'b0, nif.net_so}, ZERO);

        // 2: router delivery and drain
        nif.net_si = 1'b1; nif.net_di = PKT_A;
        tick();
        nif.net_si = 1'b0; nif.net_di = '0;
        check("t2_ri_low", {63'b0, nif.net_ri}, ZERO);
        load(2'd1); check("t2_ibs_full", nif.d_out, ONE);
        load(2'd0); check("t2_ib_data", nif.d_out, PKT_A);
        check("t2_ri_high", {63'b0, nif.net_ri}, ONE);
        load(2'd1); check("t2_ibs_empty", nif.d_out, ZERO);

        // 3: store and polarity-gated transfer
        store(2'd2, ST_V0);
        check("t3_so_pol0", {63'b0, nif.net_so}, ONE);
        check("t3_net_do", nif.net_do, ST_V0);
        nif.net_polarity = 1'b1; #1;
        check("t3_so_pol1", {63'b0, nif.net_so}, ZERO);
        nif.net_polarity = 1'b0; #1;
        check("t3_so_pol0b", {63'b0, nif.net_so}, ONE);
        load(2'd3); check("t3_obs_full", nif.d_out, ONE);
        nif.net_ro = 1'b1;
        tick();
        nif.net_ro = 1'b0;
        check("t3_so_after", {63'b0, nif.net_so}, ZERO);
        load(2'd3); check("t3_obs_empty", nif.d_out, ZERO);
        load(2'd2); check("t3_ob_keeps", nif.d_out, ST_V0);

        // 4: second store dropped; store to addr0 ignored; store+transfer collision
        store(2'd2, X1);
        store(2'd2, X2);
        check("t4_net_do", nif.net_do, X1);
        load(2'd2); check("t4_ob", nif.d_out, X1);
        store(2'd0, X3);
        load(2'd0); check("t4_ib_stale", nif.d_out, PKT_A);
        nif.net_ro = 1'b1;
        store(2'd2, X3);
        nif.net_ro = 1'b0;
        check("t4_coll_so", {63'b0, nif.net_so}, ZERO);
        check("t4_coll_do", nif.net_do, X1);
        load(2'd3); check("t4_coll_obs", nif.d_out, ZERO);
        store(2'd2, X4);
        check("t4_vc1_so", {63'b0, nif.net_so}, ZERO);
        load(2'd3); check("t4_vc1_obs", nif.d_out, ONE);

        // 5: held offer while full, accepted after drain
        nif.net_si = 1'b1; nif.net_di = P1;
        tick();
        nif.net_di = P2;
        tick();
        check("t5_ri_full", {63'b0, nif.net_ri}, ZERO);
        load(2'd0); check("t5_first", nif.d_out, P1);
        check("t5_ri_freed", {63'b0, nif.net_ri}, ONE);
        load(2'd1); check("t5_ibs_preedge", nif.d_out, ZERO);
        nif.net_si = 1'b0;
        check("t5_ri_refill", {63'b0, nif.net_ri}, ZERO);
        load(2'd0); check("t5_second", nif.d_out, P2);

        // 6: reset while both buffers full
        nif.net_si = 1'b1; nif.net_di = P3;
        tick();
        nif.net_si = 1'b0;
        nif.net_polarity = 1'b1; #1;
        check("t6_so_before", {63'b0, nif.net_so}, ONE);
        check("t6_ri_before", {63'b0, nif.net_ri}, ZERO);
        #2 reset = 1'b0; #1;
        check("t6_so_async", {63'b0, nif.net_so}, ZERO);
        check("t6_ri_async", {63'b0, nif.net_ri}, ONE);
        check("t6_do_async", nif.net_do, ZERO);
        check("t6_dout_async", nif.d_out, ZERO);
        @(negedge clk); reset = 1'b1;
        load(2'd1); check("t6_ibs", nif.d_out, ZERO);
        load(2'd3); check("t6_obs", nif.d_out, ZERO);
        load(2'd0); check("t6_ib", nif.d_out, ZERO);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
